// File: rtl/alu_cmd_issuer.sv
// Sequential front end for the 8-bit 16-opcode combinational ALU: registers a command onto the ALU, captures its result.
// Latency: accept at edge N, res_valid after N+1, next accept at N+3 with res_ready high (1 op / 3 cycles).
// Backpressure: result held in RESP until res_ready; cmd_ready stays low, so the source must hold its command.
module alu_cmd_issuer #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [3:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_zero,
    output logic             res_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic [TAG_W-1:0] tag_q;
    logic             div_by_zero;

    assign div_by_zero = ((alu_op == 4'b0011) || (alu_op == 4'b0100)) && (alu_b == '0);

    // cmd_ready mirrors the IDLE state, so it reads 1 straight out of reset.
    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tag_q     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_tag   <= '0;
            res_zero  <= 1'b0;
            res_err   <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a  <= cmd_a;
                        alu_b  <= cmd_b;
                        alu_op <= cmd_op;
                        tag_q  <= cmd_tag;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // Divide/remainder by zero masks whatever the ALU produced.
                    if (div_by_zero) begin
                        res_data <= '0;
                        res_err  <= 1'b1;
                        res_zero <= 1'b1;
                    end else begin
                        res_data <= alu_result;
                        res_err  <= 1'b0;
                        res_zero <= (alu_result == '0);
                    end
                    res_tag   <= tag_q;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Sequential front end that drives the team's 8-bit, 16-opcode combinational ALU.
- Accepts operation commands over a valid/ready handshake, registers the operands and opcode onto the ALU inputs, and captures the ALU result one cycle later.
- Returns the result with status flags over a second valid/ready handshake.
- Sits between a command source (test sequencer or controller) and the ALU. It is the initiating end of the ALU's a/b/op -> result interface.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU's width.
- TAG_W, 4, width of the command tag returned unchanged with the result.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_a  input  WIDTH  operand a.
- cmd_b  input  WIDTH  operand b.
- cmd_op  input  4  ALU opcode; encoding identical to the ALU's.
- cmd_tag  input  TAG_W  command identifier.
- alu_a  output  WIDTH  registered operand a to the ALU.
- alu_b  output  WIDTH  registered operand b to the ALU.
- alu_op  output  4  registered opcode to the ALU.
- alu_result  input  WIDTH  ALU combinational result.
- res_valid  output  1  result present.
- res_ready  input  1  consumer accepts the result.
- res_data  output  WIDTH  captured result.
- res_tag  output  TAG_W  tag of the command that produced res_data.
- res_zero  output  1  res_data == 0.
- res_err  output  1  divide or remainder by zero.
- op_count  output  CNT_W  number of completed result handshakes.

Behaviour:
- Reset: one clock, rst synchronous active-high. All outputs are 0 after reset and the state is IDLE. cmd_ready is therefore 1 in the first cycle after rst deasserts.
- States:
  - IDLE: cmd_ready=1. When cmd_valid && cmd_ready, latch cmd_a/cmd_b/cmd_op/cmd_tag into alu_a/alu_b/alu_op and an internal tag register, then go to EXEC.
  - EXEC: cmd_ready=0 and the ALU settles. At the clock edge:
    - If alu_op is 4'b0011 or 4'b0100 and alu_b == 0: res_data=0, res_err=1.
    - Otherwise: res_data=alu_result, res_err=0.
    - In both cases res_zero=(value written == 0), res_tag=latched tag, res_valid=1. Go to RESP.
  - RESP: res_valid=1. res_data, res_tag, res_zero and res_err are held stable until res_valid && res_ready. On that handshake: res_valid=0, op_count increments, go to IDLE. cmd_ready stays 0 throughout RESP.
- Latency: a command accepted at edge N gives res_valid=1 after edge N+1. With res_ready held high, the handshake completes at edge N+2 and the next command can be accepted at edge N+3. Throughput is 1 op per 3 cycles.
- alu_a, alu_b and alu_op change only on command acceptance. They hold their values through EXEC, RESP and the following IDLE.
- res_data truncation: res_data keeps the low WIDTH bits of the ALU result, with no saturation. Examples: 200+100 -> 44; 0x80*2 -> 0x00 with res_zero=1.
- res_ready asserted before res_valid has no effect.
- cmd_valid in EXEC or RESP is ignored. The command is not consumed and must be held by the source.
- op_count wraps from 2^CNT_W-1 to 0. Error results count as completed operations.
- Reset mid-operation (rst in EXEC or RESP): the in-flight result is discarded, all outputs go to 0, the state returns to IDLE and op_count is cleared.
- res_err and res_zero are both 1 for a divide-by-zero.
- Opcodes outside the decoded set do not exist, because all 16 codes are legal. Any X on alu_result propagates to res_data unchanged.

Test Plan:
- Reset then idle: after rst, check cmd_ready=1, res_valid=0, op_count=0 and all alu_* outputs = 0.
- Add with tag: a=8'd200, b=8'd100, op=0000, tag=5, res_ready=1. Expect res_valid one cycle after acceptance with res_data=8'd44, res_tag=5, res_zero=0, res_err=0, then op_count=1.
- Divide by zero: a=8'd9, b=0, op=0011. Expect res_data=0, res_err=1, res_zero=1. Repeat with op=0100 for the same response. Then a=8'd9, b=8'd2, op=0011 -> res_data=4, res_err=0.
- Backpressure: a=8'd5, op=1110, res_ready=0 for 5 cycles. Expect res_valid and res_data=6 stable, cmd_ready=0, and a new cmd_valid not accepted. Raise res_ready and the handshake completes.
- Reset in RESP: issue a=8'h80, b=2, op=0010 with res_ready=0, then pulse rst while res_valid=1. Expect res_valid=0, op_count=0, cmd_ready=1 next cycle, and no result ever delivered.
- Counter wrap: force CNT_W=2 and run 5 back-to-back ops. Expect op_count sequence 1, 2, 3, 0, 1 and a new acceptance every third cycle.
